// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: receive-path controller with error-driven baud hunting,
// frame filtering and a small valid/ready byte FIFO toward the consumer.
module rx_link_ctrl #(
   parameter int         FIFO_DEPTH   = 4,
   parameter int         LOCK_COUNT   = 4,
   parameter int         UNLOCK_COUNT = 8,
   parameter logic [1:0] DEF_BAUD     = 2'b10,
   parameter logic [1:0] DEF_PARITY   = 2'b00
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx_active_flag,
   input  logic       rx_done_flag,
   input  logic [2:0] rx_error_flag,
   input  logic [7:0] rx_data,
   output logic [1:0] baud_rate,
   output logic [1:0] parity_type,
   input  logic       cfg_load,
   input  logic [1:0] cfg_baud,
   input  logic [1:0] cfg_parity,
   input  logic       auto_baud_en,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       locked,
   output logic       overflow_flag,
   output logic [7:0] err_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);
   localparam logic [GW-1:0] GMAX = GW'(LOCK_COUNT);
   localparam logic [BW-1:0] BMAX = BW'(UNLOCK_COUNT);

   typedef enum logic {S_LOCKED = 1'b0, S_HUNT = 1'b1} state_t;

   state_t        r_state, w_state_nx;
   logic          r_done_d, r_eval, r_pend, r_ovf;
   logic [1:0]    r_baud, r_parity;
   logic [7:0]    r_err_cnt, w_err_nx, w_err_inc;
   logic [GW-1:0] r_good_cnt, w_good_nx, w_good_inc;
   logic [BW-1:0] r_bad_cnt, w_bad_nx, w_bad_inc;
   logic [AW:0]   r_wr_ptr, r_rd_ptr;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic          w_event, w_frame_err, w_push, w_step_req;
   logic          w_step, w_full, w_pop, w_wr_en;

   assign w_event     = rx_done_flag & ~r_done_d;
   assign w_frame_err = |rx_error_flag;
   assign w_err_inc   = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
   assign w_good_inc  = r_good_cnt + GW'(1);
   assign w_bad_inc   = (r_bad_cnt == BMAX) ? r_bad_cnt : r_bad_cnt + BW'(1);

   assign baud_rate     = r_baud;
   assign parity_type   = r_parity;
   assign locked        = (r_state == S_LOCKED);
   assign overflow_flag = r_ovf;
   assign err_count     = r_err_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_LOCKED;
      else          r_state <= w_state_nx;
   end

   // r_eval marks cycle E+1, where data and error flags are sampled
   always_comb begin
      w_state_nx = r_state;
      w_good_nx  = r_good_cnt;
      w_bad_nx   = r_bad_cnt;
      w_err_nx   = r_err_cnt;
      w_push     = 1'b0;
      w_step_req = 1'b0;
      if (cfg_load) begin
         w_good_nx  = '0;
         w_bad_nx   = '0;
         w_err_nx   = '0;
         w_state_nx = auto_baud_en ? S_HUNT : S_LOCKED;
      end else if (r_eval) begin
         unique case (r_state)
            S_LOCKED: begin
               if (w_frame_err) begin
                  w_bad_nx = w_bad_inc;
                  w_err_nx = w_err_inc;
                  if (auto_baud_en && (w_bad_inc == BMAX)) begin
                     w_state_nx = S_HUNT;
                     w_bad_nx   = '0;
                     w_good_nx  = '0;
                     w_step_req = 1'b1;
                  end
               end else begin
                  w_push   = 1'b1;
                  w_bad_nx = '0;
               end
            end
            S_HUNT: begin
               if (w_frame_err) begin
                  w_err_nx   = w_err_inc;
                  w_good_nx  = '0;
                  w_step_req = 1'b1;
               end else if (w_good_inc == GMAX) begin
                  w_state_nx = S_LOCKED;
                  w_good_nx  = '0;
                  w_bad_nx   = '0;
               end else begin
                  w_good_nx = w_good_inc;
               end
            end
         endcase
      end
   end

   assign w_step = r_pend | w_step_req;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_done_d   <= 1'b0;
         r_eval     <= 1'b0;
         r_pend     <= 1'b0;
         r_ovf      <= 1'b0;
         r_baud     <= DEF_BAUD;
         r_parity   <= DEF_PARITY;
         r_err_cnt  <= '0;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
      end else begin
         r_done_d   <= rx_done_flag;
         r_eval     <= w_event;
         r_err_cnt  <= w_err_nx;
         r_good_cnt <= w_good_nx;
         r_bad_cnt  <= w_bad_nx;
         if (cfg_load) begin
            r_baud   <= cfg_baud;
            r_parity <= cfg_parity;
            r_pend   <= 1'b0;
            r_ovf    <= 1'b0;
         end else begin
            if (w_step) begin
               if (rx_active_flag) begin
                  r_pend <= 1'b1;
               end else begin
                  r_baud <= r_baud + 2'd1;
                  r_pend <= 1'b0;
               end
            end
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
         end
      end
   end

   assign out_valid = (r_wr_ptr != r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = out_valid & out_ready;
   // a pop frees the head slot, so a push into a full FIFO is still taken
   assign w_wr_en   = w_push & (~w_full | w_pop);
   assign out_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule
